// File: rtl/lfsr_pkg.sv
// Shared definitions for the round-robin LFSR scheduler: LFSR geometry,
// reset value, feedback taps and the scheduler state encoding.
package lfsr_pkg;

    localparam int           LFSR_W     = 5;
    localparam logic [4:0]   LFSR_RESET = 5'b11111;
    // Feedback taps for x^5+x^3+1: bits 4 and 2 are XORed into bit 0.
    localparam logic [4:0]   LFSR_TAPS  = 5'b10100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit maximal-length LFSR with step and seed-load controls.
// A zero seed would lock the register, so it is replaced by the reset value.
module lfsr5_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (seed == '0) ? LFSR_RESET : seed;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= LFSR_RESET;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler handing out one LFSR word per grant; the LFSR is
// advanced STEPS times between grants so handed-out words share no state bits.
module lfsr_rr_sched
    import lfsr_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int STEPS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [N_REQ-1:0]  gnt,
    output logic              rnd_valid,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;

    logic             lfsr_step;
    logic             lfsr_load;
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;

    // First asserted request at or above ptr, wrapping around.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        lfsr_step = 1'b0;
        lfsr_load = 1'b0;
        gnt       = '0;
        rnd_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (found) begin
                    win_d   = pick;
                    cnt_d   = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                lfsr_step = 1'b1;
                if (cnt_q == 5'(STEPS - 1)) begin
                    state_d = GRANT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            GRANT: begin
                gnt[win_q] = 1'b1;
                rnd_valid  = 1'b1;
                ptr_d      = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    lfsr5_core u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .load (lfsr_load),
        .seed (seed),
        .q    (rnd_data)
    );

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched: a transaction-level model checked every
// cycle, plus literal grant words and grant orders worked out by hand.
module tb_lfsr_rr_sched;

    localparam int N     = 4;
    localparam int STEPS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       seed_load = 1'b0;
    logic [4:0] seed = '0;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [4:0] rnd_data;
    logic       busy;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    lfsr_rr_sched #(.N_REQ(N), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .seed_load (seed_load),
        .seed      (seed),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: LFSR value, rotating pointer, and a countdown of steps left.
    function automatic logic [4:0] m_step(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[2]};
    endfunction

    logic [4:0] m_lfsr;
    int         m_ptr, m_win, m_left;
    bit         m_grant, m_found;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = 5'b11111; m_ptr = 0; m_win = 0; m_left = 0; m_grant = 0;
        end else if (m_grant) begin
            m_grant = 0;
            m_ptr   = (m_win + 1) % N;
        end else if (m_left > 0) begin
            m_lfsr = m_step(m_lfsr);
            m_left--;
            if (m_left == 0) m_grant = 1;
        end else if (seed_load) begin
            m_lfsr = (seed == 5'd0) ? 5'b11111 : seed;
        end else if (req != 4'd0) begin
            m_found = 0;
            for (int k = 0; k < N; k++) begin
                if (!m_found && req[(m_ptr + k) % N]) begin
                    m_found = 1;
                    m_win   = (m_ptr + k) % N;
                end
            end
            m_left = STEPS;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_gnt", gnt, m_grant ? (32'd1 << m_win) : 32'd0);
            chk("model_rnd_valid", rnd_valid, m_grant);
            chk("model_busy", busy, (m_grant || m_left > 0));
            chk("model_rnd_data", rnd_data, m_lfsr);
        end
    end

    task automatic wait_grant(output logic [3:0] g, output logic [4:0] d, output int c);
        g = '0; d = '0; c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rnd_valid) begin
                g = gnt; d = rnd_data; c = cyc;
                return;
            end
        end
        chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; seed_load = 1'b0; seed = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] g;
    logic [4:0] d;
    int         c, c_prev;
    int         seen;
    logic [3:0] exp_g [5];

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rnd_valid", rnd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rnd_data", rnd_data, 5'b11111);
        rst = 1'b0;

        // Single requester held: two grants, seven cycles apart
        req = 4'b0001;
        wait_grant(g, d, c);
        chk("t1_gnt0", g, 4'b0001);
        chk("t1_data0", d, 5'b00011);
        c_prev = c;
        wait_grant(g, d, c);
        req = '0;
        chk("t1_gnt1", g, 4'b0001);
        chk("t1_data1", d, 5'b01110);
        chk("t1_spacing", c - c_prev, STEPS + 2);

        // All requesters held: rotation order and spacing
        do_reset();
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, d, c);
            chk("t2_gnt", g, exp_g[i]);
            if (i > 0) chk("t2_spacing", c - c_prev, STEPS + 2);
            c_prev = c;
        end
        req = '0;

        // Seed load wins over a same-cycle request; grant follows a cycle later
        do_reset();
        seed_load = 1'b1; seed = 5'b00001; req = 4'b0100;
        @(negedge clk);
        c_prev = cyc;
        seed_load = 1'b0;
        wait_grant(g, d, c);
        req = '0;
        chk("t3_gnt", g, 4'b0100);
        chk("t3_data", d, 5'b00101);
        chk("t3_latency", c - c_prev, STEPS + 1);

        // Zero seed substitution and seed load ignored while busy
        do_reset();
        seed_load = 1'b1; seed = 5'b00001;
        @(negedge clk);
        chk("t4_seed1", rnd_data, 5'b00001);
        seed = 5'b00000;
        @(negedge clk);
        seed_load = 1'b0;
        chk("t4_seed0", rnd_data, 5'b11111);
        req = 4'b0001;
        @(negedge clk);
        req = '0; seed_load = 1'b1; seed = 5'b01010;
        repeat (2) @(negedge clk);
        seed_load = 1'b0;
        wait_grant(g, d, c);
        chk("t4_gnt", g, 4'b0001);
        chk("t4_data", d, 5'b00011);

        // Asynchronous reset in the middle of STEP
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_data", rnd_data, 5'b11111);
        chk("t5_rst_valid", rnd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rnd_valid) seen++;
        end
        chk("t5_no_grant", seen, 0);
        req = 4'b0010;
        wait_grant(g, d, c);
        req = '0;
        chk("t5_gnt", g, 4'b0010);
        chk("t5_data", d, 5'b00011);

        // Winner kept after req drops; pointer moves past it
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = 4'b1001;
        wait_grant(g, d, c);
        chk("t6_gnt0", g, 4'b0100);
        wait_grant(g, d, c);
        chk("t6_gnt1", g, 4'b1000);
        wait_grant(g, d, c);
        req = '0;
        chk("t6_gnt2", g, 4'b0001);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/lfsr_rr_sched.md
# lfsr_rr_sched

Round-robin scheduler that shares one 5-bit maximal-length LFSR between N_REQ requesters. Per grant, it advances the LFSR STEPS times, so consecutive words handed out never share state bits. It then presents one random word to the winning requester for one cycle. Seed loading is also routed through this block; it is the only writer of the LFSR core.

## Interface
- N_REQ, 4, number of requesters (2..8)
- STEPS, 5, LFSR advances per grant (1..31)
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req  in  N_REQ  request level per requester
- seed_load  in  1  load seed into LFSR (honoured only in IDLE)
- seed  in  5  seed value
- gnt  out  N_REQ  one-hot grant, high one cycle with rnd_valid
- rnd_valid  out  1  rnd_data valid (high only in GRANT)
- rnd_data  out  5  LFSR state delivered to the winner
- busy  out  1  high in every state other than IDLE

## Operation
- LFSR step: q_next = {q[3:0], q[4]^q[2]} (x^5+x^3+1, period 31).
- LFSR reset value is 5'b11111. All-zero state is unreachable.
- seed_load in IDLE loads seed on the next edge.
  - A seed of 5'b00000 is replaced by 5'b11111.
  - seed_load has priority over req in the same cycle; the grant waits one cycle.
  - seed_load outside IDLE is ignored, with no queueing.
- FSM states:
  - IDLE:
    - seed_load → IDLE (LFSR loaded).
    - Else |req → STEP: winner latched as the first set req bit searching from ptr upward, wrapping; cnt=0.
    - Else stay IDLE.
  - STEP: LFSR steps every cycle and cnt increments. When cnt==STEPS-1 the final step is taken and the state goes to GRANT.
  - GRANT:
    - gnt[winner]=1, rnd_valid=1, rnd_data = LFSR state.
    - ptr = (winner+1) mod N_REQ.
    - Next state is IDLE.
- Winner is fixed once latched. Dropping req during STEP does not cancel the grant, and the LFSR still advances.
- rnd_data is the LFSR state at all times. It is meaningful only while rnd_valid is high.
- LFSR does not step in IDLE or GRANT.

## Timing
- Reset values: gnt=0, rnd_valid=0, busy=0, rnd_data=5'b11111, ptr=0, state=IDLE, cnt=0.
- Reset mid-operation aborts immediately. No grant is issued; LFSR returns to 5'b11111.
- Latency: req high at edge T0 in IDLE → gnt/rnd_valid high for exactly the cycle after edge T0+STEPS.
- Throughput: one grant per STEPS+2 cycles (IDLE, STEP×STEPS, GRANT).
- A requester holding req across GRANT is eligible again in the following IDLE, at lowest priority per ptr.
- ptr wraps from N_REQ-1 to 0.
- busy rises on the edge leaving IDLE and falls on the edge entering IDLE.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_W=5
  - LFSR_RESET=5'b11111
  - the state enum (IDLE, STEP, GRANT)
  - the tap constant
- One sub-module, lfsr5_core: ports clk, rst, step, load, seed, q. It performs the zero-seed substitution internally.
- The scheduler holds only the FSM, cnt, ptr, winner and the grant decode.

## Test plan
- Reset, then req=0001 held → gnt=0001 once, rnd_data=5'b00011. Next grant rnd_data=5'b01110.
- req=1111 held continuously → gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 7 cycles apart.
- seed_load with seed=5'b00001 in IDLE, then req=0100 → gnt=0100, rnd_data=5'b00101.
- seed_load with seed=5'b00000 → LFSR=5'b11111. Seed_load while busy → ignored, and the next word is unchanged from the no-load run.
- rst asserted during STEP → outputs take reset values asynchronously and no gnt is seen. After release, req=0010 → rnd_data=5'b00011.
- req dropped in the cycle after the STEP entry → gnt for that requester is still issued. ptr advances, and a simultaneous req=1001 is next granted to bit 3 if the winner was 2.
